// File: rtl/cache_line_axi_bridge_if.sv
// AXI4 master-port bundle used by cache_line_axi_bridge.
// The bridge takes the master modport; the memory (or a bench model) takes the slave modport.
interface cache_line_axi_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // Read address channel
   logic [3:0]              arid;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;
   logic [2:0]              arsize;
   logic [1:0]              arburst;
   logic                    arvalid;
   logic                    arready;
   // Read data channel
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic                    rvalid;
   logic                    rready;
   // Write address channel
   logic [3:0]              awid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;
   // Write data channel
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;
   // Write response channel
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/cache_line_axi_bridge.sv
// Memory-side stage below the cache: turns one line refill or dirty-line
// writeback into a single AXI4 INCR burst and returns the line (or the write
// completion) through a one-entry response handshake.
// Optional feature macro: KUUGA_LINE_XFER_STATS_EN adds saturating
// refill/writeback/error counters on extra output ports.
module cache_line_axi_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LINE_WORDS = 4,
   parameter int AXI_ID     = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_we,
   input  logic [ADDR_WIDTH-1:0]            req_addr,
   input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wdata,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [LINE_WORDS*DATA_WIDTH-1:0] rsp_rdata,
   output logic                             rsp_err,
   cache_line_axi_bridge_if.master          m_axi
`ifdef KUUGA_LINE_XFER_STATS_EN
   ,
   output logic [31:0]                      stat_refills,
   output logic [31:0]                      stat_writebacks,
   output logic [31:0]                      stat_errors
`endif
);

   localparam int BEAT_W   = $clog2(LINE_WORDS);
   localparam int OFFSET_W = $clog2(LINE_WORDS*4);
   localparam int LINE_W   = LINE_WORDS*DATA_WIDTH;
   localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(LINE_WORDS-1);
   localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_W) - 1);
   localparam logic [3:0]            ID_VAL      = 4'(AXI_ID);

   typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, RESP} state_t;

   state_t                  state;
   state_t                  next_state;
   logic                    ready_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [LINE_W-1:0]       line_q;
   logic                    err_q;
   logic [BEAT_W-1:0]       beat_q;
   logic                    accept;
   logic                    ar_valid;
   logic                    r_ready;
   logic                    aw_valid;
   logic                    w_valid;
   logic                    b_ready;

   assign accept    = req_valid && req_ready;
   assign req_ready = ready_q;
   assign rsp_rdata = line_q;
   assign rsp_err   = err_q;

   assign m_axi.arid    = ID_VAL;
   assign m_axi.araddr  = addr_q;
   assign m_axi.arlen   = 8'(LINE_WORDS-1);
   assign m_axi.arsize  = 3'b010;
   assign m_axi.arburst = 2'b01;
   assign m_axi.arvalid = ar_valid;
   assign m_axi.rready  = r_ready;
   assign m_axi.awid    = ID_VAL;
   assign m_axi.awaddr  = addr_q;
   assign m_axi.awlen   = 8'(LINE_WORDS-1);
   assign m_axi.awsize  = 3'b010;
   assign m_axi.awburst = 2'b01;
   assign m_axi.awvalid = aw_valid;
   assign m_axi.wdata   = line_q[beat_q*DATA_WIDTH +: DATA_WIDTH];
   assign m_axi.wstrb   = '1;
   assign m_axi.wlast   = w_valid && (beat_q == LAST_BEAT);
   assign m_axi.wvalid  = w_valid;
   assign m_axi.bready  = b_ready;

   // State register; reset drops any burst in flight straight back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Request ready is registered so it stays low throughout reset and rises
   // on the first edge after release, then tracks the IDLE state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_q <= 1'b0;
      else        ready_q <= (next_state == IDLE);
   end

   // Next-state and channel handshake outputs; only one channel is ever active.
   always_comb begin
      next_state = state;
      ar_valid   = 1'b0;
      r_ready    = 1'b0;
      aw_valid   = 1'b0;
      w_valid    = 1'b0;
      b_ready    = 1'b0;
      rsp_valid  = 1'b0;
      case (state)
         IDLE: if (accept) next_state = req_we ? AW : AR;
         AR: begin
            ar_valid = 1'b1;
            if (m_axi.arready) next_state = R;
         end
         R: begin
            r_ready = 1'b1;
            if (m_axi.rvalid && (m_axi.rlast || beat_q == LAST_BEAT)) next_state = RESP;
         end
         AW: begin
            aw_valid = 1'b1;
            if (m_axi.awready) next_state = W;
         end
         W: begin
            w_valid = 1'b1;
            if (m_axi.wready && beat_q == LAST_BEAT) next_state = B;
         end
         B: begin
            b_ready = 1'b1;
            if (m_axi.bvalid) next_state = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Line buffer, aligned address, error flag and beat counter. The counter
   // saturates at the last word so a long or late-rlast burst cannot wrap it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         line_q <= '0;
         err_q  <= 1'b0;
         beat_q <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               addr_q <= req_addr & ~OFFSET_MASK;
               line_q <= req_we ? req_wdata : '0;
               err_q  <= 1'b0;
               beat_q <= '0;
            end
            R: if (m_axi.rvalid) begin
               line_q[beat_q*DATA_WIDTH +: DATA_WIDTH] <= m_axi.rdata;
               err_q <= err_q | (m_axi.rresp != 2'b00);
               if (beat_q != LAST_BEAT) beat_q <= beat_q + BEAT_W'(1);
            end
            W: if (m_axi.wready && beat_q != LAST_BEAT) beat_q <= beat_q + BEAT_W'(1);
            B: if (m_axi.bvalid) err_q <= err_q | (m_axi.bresp != 2'b00);
            default: ;
         endcase
      end
   end

`ifdef KUUGA_LINE_XFER_STATS_EN
   logic we_q;

   // Remember the transaction type so the right counter bumps at completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        we_q <= 1'b0;
      else if (state == IDLE && accept)  we_q <= req_we;
   end

   // Saturating counters advanced on the response handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_refills    <= '0;
         stat_writebacks <= '0;
         stat_errors     <= '0;
      end else if (rsp_valid && rsp_ready) begin
         if (we_q) begin
            if (stat_writebacks != '1) stat_writebacks <= stat_writebacks + 32'd1;
         end else begin
            if (stat_refills != '1) stat_refills <= stat_refills + 32'd1;
         end
         if (rsp_err && stat_errors != '1) stat_errors <= stat_errors + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_line_axi_bridge.sv
// Directed bench for cache_line_axi_bridge with a small AXI slave memory model.
// Build with KUUGA_LINE_XFER_STATS_EN defined to also check the counters.
module tb_cache_line_axi_bridge;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [31:0]   req_addr;
   logic [127:0]  req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [127:0]  rsp_rdata;
   logic          rsp_err;
`ifdef KUUGA_LINE_XFER_STATS_EN
   logic [31:0]   stat_refills;
   logic [31:0]   stat_writebacks;
   logic [31:0]   stat_errors;
`endif

   cache_line_axi_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_axi ();

   cache_line_axi_bridge #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(4), .AXI_ID(0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .m_axi     (m_axi.master)
`ifdef KUUGA_LINE_XFER_STATS_EN
      ,
      .stat_refills    (stat_refills),
      .stat_writebacks (stat_writebacks),
      .stat_errors     (stat_errors)
`endif
   );

   int            total_checks = 0;
   int            bad_checks   = 0;

   logic [31:0]   mem [0:255];
   bit            delay_en   = 1'b0;
   int            err_beat   = -1;
   logic [31:0]   ar_addr_seen;
   logic [7:0]    ar_len_seen;
   logic [31:0]   aw_addr_seen;
   int            r_beats    = 0;
   int            w_beats    = 0;
   logic [127:0]  w_line;
   logic [3:0]    wlast_bits;
   logic [3:0]    wstrb_and;
   bit            b_seen     = 1'b0;
   bit            rsp_after_b;

   // free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total_checks++;
      if (got !== exp) begin
         bad_checks++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int dly();
      return delay_en ? int'($urandom_range(7, 0)) : 0;
   endfunction

   // read slave: one AR then up to arlen+1 beats, optional random stalls
   initial begin : read_slave
      bit ok;
      int base;
      m_axi.arready = 1'b0;
      m_axi.rvalid  = 1'b0;
      m_axi.rdata   = '0;
      m_axi.rresp   = 2'b00;
      m_axi.rlast   = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && m_axi.arvalid) begin
            repeat (dly()) @(negedge clk);
            ar_addr_seen  = m_axi.araddr;
            ar_len_seen   = m_axi.arlen;
            m_axi.arready = 1'b1;
            @(negedge clk);
            m_axi.arready = 1'b0;
            base = int'(ar_addr_seen[9:2]);
            for (int b = 0; b <= int'(ar_len_seen) && rst_n; b++) begin
               repeat (dly()) @(negedge clk);
               m_axi.rdata  = mem[(base + b) & 255];
               m_axi.rresp  = (b == err_beat) ? 2'b10 : 2'b00;
               m_axi.rlast  = (b == int'(ar_len_seen));
               m_axi.rvalid = 1'b1;
               ok = 1'b0;
               while (!ok && rst_n) begin
                  ok = m_axi.rready;
                  @(negedge clk);
               end
               m_axi.rvalid = 1'b0;
               m_axi.rlast  = 1'b0;
               if (ok) r_beats++;
            end
         end
      end
   end

   // write slave: AW, W beats logged and stored, then B
   initial begin : write_slave
      bit ok;
      int base;
      m_axi.awready = 1'b0;
      m_axi.wready  = 1'b0;
      m_axi.bvalid  = 1'b0;
      m_axi.bresp   = 2'b00;
      forever begin
         @(negedge clk);
         if (rst_n && m_axi.awvalid) begin
            repeat (dly()) @(negedge clk);
            aw_addr_seen  = m_axi.awaddr;
            m_axi.awready = 1'b1;
            @(negedge clk);
            m_axi.awready = 1'b0;
            base = int'(aw_addr_seen[9:2]);
            for (int b = 0; b <= int'(m_axi.awlen) && rst_n; b++) begin
               repeat (dly()) @(negedge clk);
               m_axi.wready = 1'b1;
               ok = 1'b0;
               while (!ok && rst_n) begin
                  ok = m_axi.wvalid;
                  if (ok) begin
                     mem[(base + b) & 255] = m_axi.wdata;
                     w_line[b*32 +: 32]    = m_axi.wdata;
                     wlast_bits[b]         = m_axi.wlast;
                     wstrb_and             = wstrb_and & m_axi.wstrb;
                  end
                  @(negedge clk);
               end
               m_axi.wready = 1'b0;
               if (ok) w_beats++;
            end
            if (rst_n) begin
               repeat (dly()) @(negedge clk);
               m_axi.bresp  = 2'b00;
               m_axi.bvalid = 1'b1;
               b_seen       = 1'b1;
               ok = 1'b0;
               while (!ok && rst_n) begin
                  ok = m_axi.bready;
                  @(negedge clk);
               end
               m_axi.bvalid = 1'b0;
            end
         end
      end
   end

   // present a request at a negedge; returns one negedge after acceptance with req_valid still high
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [127:0] wdata);
      int cnt = 0;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      while (!req_ready && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("req_accept", req_ready, 1);
      @(negedge clk);
   endtask

   // wait for the response, hold rsp_ready low for 'hold' cycles checking stability, then accept
   task automatic waitResponse(input int hold, input string tag, output logic [127:0] line, output logic err);
      int cnt = 0;
      while (!rsp_valid && cnt < 500) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput({tag, "_rsp_valid"}, rsp_valid, 1);
      line        = rsp_rdata;
      err         = rsp_err;
      rsp_after_b = b_seen;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         checkOutput({tag, "_hold_valid"}, rsp_valid, 1);
         checkOutput({tag, "_hold_rdata"}, rsp_rdata, line);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   // safety net against a hung handshake
   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   localparam logic [127:0] LINE_100 = 128'h00000043_00000042_00000041_00000040;
   localparam logic [127:0] LINE_000 = 128'h00000003_00000002_00000001_00000000;
   localparam logic [127:0] WB_200   = 128'h0000000D_0000000C_0000000B_0000000A;
   localparam logic [127:0] WB_300   = 128'h11112222_33334444_55556666_77778888;
   localparam logic [127:0] WB_010   = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;

   initial begin : main
      logic [127:0] line;
      logic         err;
      int           cnt;
      bit           seen;

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 32'(i);

      repeat (3) @(negedge clk);
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 0);
      checkOutput("rst_rsp_err",   rsp_err, 0);
      checkOutput("rst_arvalid",   m_axi.arvalid, 0);
      checkOutput("rst_awvalid",   m_axi.awvalid, 0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle_req_ready", req_ready, 1);

      // refill at an unaligned address
      applyStimulus(1'b0, 32'h104, '0);
      checkOutput("refill_arvalid_latency", m_axi.arvalid, 1);
      req_valid = 1'b0;
      waitResponse(0, "refill", line, err);
      checkOutput("refill_araddr", ar_addr_seen, 32'h100);
      checkOutput("refill_arlen",  ar_len_seen, 3);
      checkOutput("refill_rdata",  line, LINE_100);
      checkOutput("refill_err",    err, 0);

      // writeback
      w_beats = 0; wlast_bits = '0; wstrb_and = '1; b_seen = 1'b0;
      applyStimulus(1'b1, 32'h200, WB_200);
      checkOutput("wb_awvalid_latency", m_axi.awvalid, 1);
      checkOutput("wb_no_early_wvalid", m_axi.wvalid, 0);
      req_valid = 1'b0;
      waitResponse(0, "wb", line, err);
      checkOutput("wb_awaddr",      aw_addr_seen, 32'h200);
      checkOutput("wb_beats",       w_beats, 4);
      checkOutput("wb_wdata_log",   w_line, WB_200);
      checkOutput("wb_wlast_pos",   wlast_bits, 4'b1000);
      checkOutput("wb_wstrb",       wstrb_and, 4'hF);
      checkOutput("wb_mem",         {mem[8'h83], mem[8'h82], mem[8'h81], mem[8'h80]}, WB_200);
      checkOutput("wb_rsp_after_b", rsp_after_b, 1);
      checkOutput("wb_rsp_rdata",   line, WB_200);
      checkOutput("wb_err",         err, 0);

      // backpressure on every channel plus a stalled response
      delay_en = 1'b1;
      applyStimulus(1'b0, 32'h104, '0);
      req_valid = 1'b0;
      waitResponse(5, "bp_refill", line, err);
      checkOutput("bp_refill_rdata", line, LINE_100);
      checkOutput("bp_refill_err",   err, 0);
      w_beats = 0; wlast_bits = '0; wstrb_and = '1; b_seen = 1'b0;
      applyStimulus(1'b1, 32'h300, WB_300);
      req_valid = 1'b0;
      waitResponse(5, "bp_wb", line, err);
      checkOutput("bp_wb_beats",    w_beats, 4);
      checkOutput("bp_wb_wlast",    wlast_bits, 4'b1000);
      checkOutput("bp_wb_mem",      {mem[8'hC3], mem[8'hC2], mem[8'hC1], mem[8'hC0]}, WB_300);
      checkOutput("bp_wb_rsp_after_b", rsp_after_b, 1);
      delay_en = 1'b0;

      // SLVERR on the second read beat
      err_beat = 1;
      r_beats  = 0;
      applyStimulus(1'b0, 32'h100, '0);
      req_valid = 1'b0;
      waitResponse(0, "err", line, err);
      checkOutput("err_beats_consumed", r_beats, 4);
      checkOutput("err_flag",  err, 1);
      checkOutput("err_rdata", line, LINE_100);
      err_beat = -1;
`ifdef KUUGA_LINE_XFER_STATS_EN
      checkOutput("stat_refills_a",    stat_refills, 3);
      checkOutput("stat_writebacks_a", stat_writebacks, 2);
      checkOutput("stat_errors_a",     stat_errors, 1);
`endif

      // reset in the middle of a refill burst
      r_beats = 0;
      applyStimulus(1'b0, 32'h100, '0);
      req_valid = 1'b0;
      cnt = 0;
      while (r_beats < 1 && cnt < 100) begin
         @(posedge clk);
         #2;
         cnt++;
      end
      checkOutput("mid_reset_beat_seen", (r_beats >= 1), 1);
      checkOutput("mid_reset_in_burst",  m_axi.rready, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_reset_req_ready", req_ready, 0);
      checkOutput("mid_reset_rsp_valid", rsp_valid, 0);
      checkOutput("mid_reset_rready",    m_axi.rready, 0);
      checkOutput("mid_reset_arvalid",   m_axi.arvalid, 0);
      checkOutput("mid_reset_rdata",     rsp_rdata, 0);
      checkOutput("mid_reset_err",       rsp_err, 0);
`ifdef KUUGA_LINE_XFER_STATS_EN
      checkOutput("mid_reset_stat_refills", stat_refills, 0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      checkOutput("mid_reset_no_rsp", seen, 0);
      applyStimulus(1'b0, 32'h100, '0);
      req_valid = 1'b0;
      waitResponse(0, "post_reset", line, err);
      checkOutput("post_reset_rdata", line, LINE_100);
      checkOutput("post_reset_err",   err, 0);

      // back-to-back: refill 0x0 then writeback 0x10 with req_valid held
      w_beats = 0; wlast_bits = '0; wstrb_and = '1; b_seen = 1'b0;
      applyStimulus(1'b0, 32'h0, '0);
      req_we    = 1'b1;
      req_addr  = 32'h10;
      req_wdata = WB_010;
      waitResponse(0, "b2b_refill", line, err);
      checkOutput("b2b_refill_rdata", line, LINE_000);
      checkOutput("b2b_ready_after_rsp", req_ready, 1);
      checkOutput("b2b_not_yet_aw",      m_axi.awvalid, 0);
      @(negedge clk);
      checkOutput("b2b_second_accepted", m_axi.awvalid, 1);
      req_valid = 1'b0;
      waitResponse(0, "b2b_wb", line, err);
      checkOutput("b2b_wb_beats", w_beats, 4);
      checkOutput("b2b_wb_mem",   {mem[7], mem[6], mem[5], mem[4]}, WB_010);
      checkOutput("b2b_wb_rdata", line, WB_010);
`ifdef KUUGA_LINE_XFER_STATS_EN
      checkOutput("stat_refills_b",    stat_refills, 2);
      checkOutput("stat_writebacks_b", stat_writebacks, 1);
      checkOutput("stat_errors_b",     stat_errors, 0);
`endif

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule

// File: doc/cache_line_axi_bridge.md
Name: cache_line_axi_bridge

Overview:
- Memory-side stage directly downstream of the n-way complex cache.
- Converts one cache line refill (read) or dirty-line writeback (write) request into a single AXI4 INCR burst on a master port.
- The master port is connected to the AXI VIP slave memory, or to the data/instruction memory in hardware.
- Returns the assembled line, or the write completion, to the cache through a one-entry response handshake.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, AXI data bus and cache word width; 32 only.
- LINE_WORDS, 4, words per cache line; power of two, 2..16.
- AXI_ID, 0, constant ARID/AWID value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  cache request valid
- req_ready  out  1  bridge accepts request
- req_we  in  1  1=writeback, 0=refill
- req_addr  in  ADDR_WIDTH  line address; low log2(LINE_WORDS*4) bits ignored and forced to 0
- req_wdata  in  LINE_WORDS*DATA_WIDTH  writeback line; word 0 in bits [31:0]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  cache accepts response
- rsp_rdata  out  LINE_WORDS*DATA_WIDTH  refilled line, same packing as req_wdata
- rsp_err  out  1  any RRESP/BRESP != OKAY in the transaction
- m_axi_ar{id,addr,len,size,burst,valid}  out; m_axi_arready in
- m_axi_r{data,resp,last,valid}  in; m_axi_rready out
- m_axi_aw{id,addr,len,size,burst,valid}  out; m_axi_awready in
- m_axi_w{data,strb,last,valid}  out; m_axi_wready in
- m_axi_b{resp,valid}  in; m_axi_bready out

Behaviour:
- Reset (async assert, sync deassert use): state IDLE, all valid/ready outputs 0, rsp_rdata 0, rsp_err 0, beat counter 0.
- Constant burst fields: len=LINE_WORDS-1, size=3'b010, burst=INCR, wstrb=4'hF.
- FSM states: IDLE, AR, R, AW, W, B, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch aligned addr, we and wdata; clear err and beat counter.
  - Go to AW if we=1, else AR.
  - Request-to-arvalid/awvalid latency is 1 cycle.
- AR: arvalid=1 until arready (address held stable), then go to R.
- R:
  - rready=1.
  - Each rvalid beat stores rdata into word[beat]; beat++; OR (rresp!=0) into err.
  - Beat with rlast, or with beat==LINE_WORDS-1, goes to RESP.
  - rlast early or late is tolerated; the counter governs. Extra beats after the count are not consumed.
- AW: awvalid=1 until awready, then go to W. wvalid is not raised before the AW handshake.
- W:
  - wvalid=1, wdata=word[beat], wlast=(beat==LINE_WORDS-1).
  - beat++ on wready.
  - Last beat accepted goes to B.
- B: bready=1; on bvalid, err |= (bresp!=0), then go to RESP.
- RESP:
  - rsp_valid=1 with rsp_rdata/rsp_err stable until rsp_ready.
  - For writeback, rsp_rdata holds the written line.
  - Go to IDLE on rsp_ready.
  - The next request is accepted one cycle later; no back-to-back overlap.
- Only one outstanding transaction at a time; read and write channels are never active together.
- Beat counter width is log2(LINE_WORDS). It never wraps within a transaction.
- rst_n asserted mid-burst returns the FSM to IDLE immediately. The partial line is discarded and no response is produced. The interconnect is reset by the same rst_n.
- Stalls of any length on arready/awready/wready/rvalid/bvalid and rsp_ready are tolerated with no data loss.

Optional Feature:
- Macro: KUUGA_LINE_XFER_STATS_EN.
- Enabled:
  - Adds output ports stat_refills, stat_writebacks, stat_errors, each 32 bits, reset to 0.
  - Each counter increments by 1 on the RESP handshake of the matching transaction type; stat_errors increments when rsp_err=1.
  - Counters saturate at 32'hFFFFFFFF.
- Disabled: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Refill:
  - Stimulus: VIP memory backdoor filled with word i at byte i*4; req_we=0, req_addr=0x104.
  - Required: araddr=0x100, arlen=3, rsp_rdata={0x43,0x42,0x41,0x40}, rsp_err=0.
- Writeback:
  - Stimulus: req_we=1, addr=0x200, wdata={0xD,0xC,0xB,0xA}.
  - Required: 4 W beats 0xA..0xD, wlast only on beat 4. Backdoor read of 0x200..0x20C gives 0xA..0xD; rsp_valid only after bvalid.
- Backpressure:
  - Stimulus: VIP random ready/valid delays 0-7 cycles; rsp_ready held low for 5 cycles.
  - Required: data identical to the refill case; rsp_valid and rsp_rdata stable for all 5 stalled cycles.
- Error:
  - Stimulus: VIP returns RRESP=SLVERR on beat 2 of a refill.
  - Required: all 4 beats consumed, rsp_err=1. With stats enabled, stat_errors=1 and stat_refills=1.
- Reset mid-burst:
  - Stimulus: rst_n low after R beat 1.
  - Required: all outputs return to reset values asynchronously; no rsp_valid is produced. A following refill at 0x100 completes correctly.
- Back-to-back:
  - Stimulus: req_valid held with refill 0x0, then writeback 0x10.
  - Required: the second request is accepted one cycle after the first response handshake; the write completes with correct data.
